// File: rtl/game_port_joy_if.sv
// Game-port joystick bus: I/O-decode strobe, runtime config, stick inputs and port read data.
interface game_port_joy_if #(
    parameter int unsigned NUM_JOY      = 2,
    parameter int unsigned AXES_PER_JOY = 2,
    parameter int unsigned BTN_PER_JOY  = 2,
    parameter int unsigned POS_W        = 8,
    parameter int unsigned DIV_W        = 8
);
    localparam int unsigned NUM_AXES = NUM_JOY * AXES_PER_JOY;
    localparam int unsigned OUT_W    = NUM_JOY * (AXES_PER_JOY + BTN_PER_JOY);

    logic                        trigger;
    logic [DIV_W-1:0]            pulse_div;
    logic [NUM_JOY-1:0]          joy_type;
    logic [NUM_AXES-1:0]         axis_invert;
    logic [NUM_JOY*32-1:0]       joy_dig;
    logic [NUM_AXES*POS_W-1:0]   joy_ana;
    logic [OUT_W-1:0]            d_out;
    logic                        busy;

    modport master (
        output trigger, pulse_div, joy_type, axis_invert, joy_dig, joy_ana,
        input  d_out, busy
    );

    modport slave (
        input  trigger, pulse_div, joy_type, axis_invert, joy_dig, joy_ana,
        output d_out, busy
    );
endinterface

// File: rtl/game_port_joy.sv
// PC game-port joystick front end: one-shot axis pulses with width proportional to position.
module game_port_joy #(
    parameter int unsigned NUM_JOY      = 2,
    parameter int unsigned AXES_PER_JOY = 2,
    parameter int unsigned BTN_PER_JOY  = 2,
    parameter int unsigned POS_W        = 8,
    parameter int unsigned DIV_W        = 8,
    parameter int unsigned DEADZONE     = 16,
    parameter int unsigned MIN_TICKS    = 0
) (
    input  logic           clk,
    input  logic           reset,
    game_port_joy_if.slave bus
);
    localparam int unsigned NUM_AXES = NUM_JOY * AXES_PER_JOY;
    localparam int unsigned NUM_BTN  = NUM_JOY * BTN_PER_JOY;
    localparam int unsigned CW       = POS_W + 1;
    localparam int unsigned CENTER   = 1 << (POS_W - 1);
    localparam int unsigned PMAX     = (1 << POS_W) - 1;
    localparam int unsigned CMAX     = (1 << CW) - 1;
    localparam int unsigned DZ_LO    = (DEADZONE > CENTER) ? 0 : CENTER - DEADZONE;
    localparam int unsigned DZ_HI    = (CENTER + DEADZONE > PMAX) ? PMAX : CENTER + DEADZONE;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_COUNT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic [CW-1:0]    cnt_q [NUM_AXES];
    logic [CW-1:0]    cnt_d [NUM_AXES];
    logic [CW-1:0]    load_c [NUM_AXES];
    logic [CW-1:0]    dec_c [NUM_AXES];
    logic [NUM_AXES-1:0] cnt_nz_c, load_nz_c, dec_nz_c;
    logic             unused_dig;

    // Only the D-pad and button bits of each 32-bit stick word are meaningful.
    assign unused_dig = ^bus.joy_dig;

    for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_axis
        localparam int unsigned J = gi / AXES_PER_JOY;
        localparam int unsigned A = gi % AXES_PER_JOY;

        logic [POS_W-1:0] raw_c, inv_c, pos_c;
        logic [31:0]      sum_c;

        // Position source, inversion, deadzone and minimum-time offset for this axis.
        always_comb begin
            if (bus.joy_type[J]) begin
                if (bus.joy_dig[32*J + 2*A])
                    raw_c = POS_W'(PMAX);
                else if (bus.joy_dig[32*J + 2*A + 1])
                    raw_c = '0;
                else
                    raw_c = POS_W'(CENTER);
            end else begin
                raw_c = bus.joy_ana[gi*POS_W +: POS_W] ^ POS_W'(CENTER);
            end
            inv_c = bus.axis_invert[gi] ? ~raw_c : raw_c;
            pos_c = (32'(inv_c) >= DZ_LO && 32'(inv_c) <= DZ_HI) ? POS_W'(CENTER) : inv_c;
            sum_c = 32'(pos_c) + MIN_TICKS;
        end

        assign load_c[gi]    = (sum_c > CMAX) ? CW'(CMAX) : CW'(sum_c);
        assign cnt_nz_c[gi]  = |cnt_q[gi];
        assign dec_c[gi]     = cnt_q[gi] - CW'(cnt_nz_c[gi]);
        assign load_nz_c[gi] = |load_c[gi];
        assign dec_nz_c[gi]  = |dec_c[gi];
        assign bus.d_out[gi] = cnt_nz_c[gi];
    end

    // Buttons are active-low passthroughs, independent of the measurement.
    for (genvar gb = 0; gb < NUM_BTN; gb++) begin : g_btn
        localparam int unsigned JB = gb / BTN_PER_JOY;
        localparam int unsigned B  = gb % BTN_PER_JOY;
        assign bus.d_out[NUM_AXES + gb] = ~bus.joy_dig[32*JB + 4 + B];
    end

    assign bus.busy = |cnt_nz_c;

    // Next state: trigger reloads (beats a tick); otherwise prescale and tick down.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        if (bus.trigger) begin
            cnt_d   = load_c;
            pre_d   = '0;
            state_d = (|load_nz_c) ? S_COUNT : S_IDLE;
        end else if (state_q == S_COUNT) begin
            if (pre_q == bus.pulse_div) begin
                cnt_d   = dec_c;
                pre_d   = '0;
                state_d = (|dec_nz_c) ? S_COUNT : S_IDLE;
            end else begin
                pre_d = pre_q + DIV_W'(1);
            end
        end
    end

    // State, prescaler and axis count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            cnt_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: doc/game_port_joy.md
Name: game_port_joy

Overview:
- Parametrised PC game-port joystick front end: N joysticks, 1-2 analog axes and up to 4 buttons per stick.
- Converts analog or D-pad inputs into one-shot axis pulses whose widths are proportional to position, as read by software polling the game port.
- Generalises the fixed two-stick Tandy/PCjr block:
  - position width and deadzone are parameters;
  - per-axis inversion;
  - minimum pulse offset;
  - runtime prescaler input (replaces the hard-coded turbo table);
  - busy status.
- Sits behind the I/O decode; `trigger` is the port-write strobe.

Parameters:
- NUM_JOY, 2, number of joysticks (1-4).
- AXES_PER_JOY, 2, axes per joystick (1-2).
- BTN_PER_JOY, 2, buttons per joystick (1-4).
- POS_W, 8, position width in bits; CENTER = 2^(POS_W-1).
- DIV_W, 8, prescaler width.
- DEADZONE, 16, half-width of the centre deadzone in position LSBs.
- MIN_TICKS, 0, ticks added to every loaded axis count (emulates the RC minimum time).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- trigger  in  1  one-cycle high strobe; starts/restarts a measurement.
- pulse_div  in  DIV_W  prescaler terminal value; tick period = pulse_div+1 clocks.
- joy_type  in  NUM_JOY  per stick: 0 = analog input, 1 = D-pad input.
- axis_invert  in  NUM_JOY*AXES_PER_JOY  per-axis inversion enable.
- joy_dig  in  NUM_JOY*32  D-pad/button words, stick j at [32j+31:32j].
- joy_ana  in  NUM_JOY*AXES_PER_JOY*POS_W  signed two's-complement axis values, axis a of stick j at index j*AXES_PER_JOY+a.
- d_out  out  NUM_JOY*(AXES_PER_JOY+BTN_PER_JOY)  low part: axis bits (index j*AXES_PER_JOY+a); high part: active-low buttons (index j*BTN_PER_JOY+b).
- busy  out  1  high while any axis count is nonzero.

Behaviour:
- Reset (reset=0, async): all axis counts 0, prescaler 0, state IDLE. Axis bits of d_out = 0, busy = 0. Button bits keep following the inputs.
- Position for axis a of stick j:
  - D-pad mode: bit 2a set gives 2^POS_W-1; else bit 2a+1 set gives 0; else CENTER. Bit 2a has priority over 2a+1 when both are set.
  - Analog mode: position = signed value + CENTER, computed mod 2^POS_W (equivalent to flipping the MSB).
- Inversion: if axis_invert set, position = (2^POS_W-1) - position. Applied before the deadzone.
- Deadzone: position in [CENTER-DEADZONE, CENTER+DEADZONE] inclusive is replaced by CENTER. Clamp the bounds to the 0..2^POS_W-1 range.
- Loaded count = position + MIN_TICKS. Count width is POS_W+1 bits, saturating at its all-ones value.
- FSM:
  - IDLE: trigger -> load all counts, prescaler := 0, go to COUNT. If all loaded counts are 0, stay IDLE.
  - COUNT, trigger: same as IDLE (reload all counts, prescaler := 0). Retrigger always wins over a tick in the same cycle.
  - COUNT, prescaler == pulse_div: tick. Every nonzero count decrements by 1, prescaler := 0.
  - COUNT, otherwise: prescaler increments.
  - COUNT exits to IDLE on the edge where the last nonzero count reaches 0.
  - In IDLE the prescaler holds at 0.
- Timing: an axis loaded with L at edge k shows its d_out bit high from just after edge k. The bit falls just after edge k + L*(pulse_div+1). L=0 gives a bit that never rises.
- pulse_div = 0: tick every clock. A pulse_div change mid-measurement takes effect at the next compare; the prescaler is not cleared. If the prescaler already exceeds the new value, it counts on until it wraps to pulse_div.
- Axis d_out bit = (count != 0), driven straight from registers. busy = OR of all counts.
- Button d_out bit = ~joy_dig[32j+4+b], combinational passthrough, independent of FSM state and reset.
- Inputs are sampled only on trigger edges. Changes in joy_ana, joy_dig axis bits, or axis_invert during COUNT do not affect the running pulse.

Test Plan:
- Defaults, pulse_div=3, stick0 analog, axis0 = 0x40: trigger -> d_out[0] high for exactly 192*4 = 768 clocks, then busy falls the same edge if no other axis is active.
- Analog axis = 0x0C (position 0x8C, inside the deadzone) -> count 128; with pulse_div=0, high for 128 clocks. Axis = 0x11 (0x91) -> 145 clocks.
- D-pad mode, stick1 left (bit1) and up (bit3): axis bits stay 0 on trigger. Both bits 0 and 1 set -> 255 ticks. Button bits 4,5 set -> d_out top bits for stick1 read 0.
- Retrigger at clock 100 of a 768-clock pulse -> pulse ends 768 clocks after the second trigger. Trigger coincident with a tick -> reload, no decrement.
- Async reset asserted mid-COUNT -> axis bits and busy drop without a clock edge. After release, no pulse until the next trigger.
- axis_invert=1, analog 0x40 -> position 0x3F, 63 ticks. MIN_TICKS=24 with pulse_div=0 -> 87 clocks. Saturation check with POS_W=8, MIN_TICKS=400 -> 511 ticks.
